// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-adder error evaluation engine:
// sweep state encoding, accumulator width helpers and a popcount helper.
`timescale 1ns/1ps
package approx_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_e;

  // Worst-case accumulator widths for a WIDTH-bit adder swept over all
  // 2^(2*WIDTH) operand pairs; chosen so no accumulator can ever overflow.
  function automatic int acc_abs_w(input int w);
    return 2 * w + (w + 1);
  endfunction

  function automatic int acc_sq_w(input int w);
    return 2 * w + 2 * (w + 1);
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int hd_w(input int w);
    return 2 * w + $clog2(w + 2);
  endfunction

  // Widths for the default 8-bit library configuration.
  localparam int DEF_WIDTH = 8;
  localparam int ACC_ABS_W = acc_abs_w(DEF_WIDTH);
  localparam int ACC_SQ_W  = acc_sq_w(DEF_WIDTH);
  localparam int CNT_W     = cnt_w(DEF_WIDTH);
  localparam int HD_W      = hd_w(DEF_WIDTH);

  // Number of set bits in a vector of up to 64 bits.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/add_err_acc.sv
// Compare stage and error accumulators: checks one aligned DUT result per
// valid cycle against the exact sum and folds it into the five metrics.
`timescale 1ns/1ps
module add_err_acc
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          valid,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic [WIDTH:0]                o,
  output logic [acc_abs_w(WIDTH)-1:0]   sum_abs,
  output logic [acc_sq_w(WIDTH)-1:0]    sum_sq,
  output logic [WIDTH:0]                wce,
  output logic [cnt_w(WIDTH)-1:0]       err_cnt,
  output logic [hd_w(WIDTH)-1:0]        hd_sum
);

  localparam int OW    = WIDTH + 1;
  localparam int ABS_W = acc_abs_w(WIDTH);
  localparam int SQ_W  = acc_sq_w(WIDTH);
  localparam int C_W   = cnt_w(WIDTH);
  localparam int H_W   = hd_w(WIDTH);

  logic [WIDTH:0]        exact;
  logic [WIDTH+1:0]      err;
  logic [WIDTH:0]        abs_err;
  logic [2*OW-1:0]       sq;
  logic [7:0]            hd;

  // Signed error O - (A+B) is one bit wider than the sum; its magnitude
  // always fits back into WIDTH+1 bits.
  always_comb begin
    exact   = {1'b0, a} + {1'b0, b};
    err     = {1'b0, o} - {1'b0, exact};
    abs_err = err[WIDTH+1] ? OW'(~err + 1'b1) : err[WIDTH:0];
    sq      = {{OW{1'b0}}, abs_err} * {{OW{1'b0}}, abs_err};
    hd      = popcount(64'(o ^ exact));
  end

  // Registered accumulation; a clear restarts all metrics for a new sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_abs <= '0;
      sum_sq  <= '0;
      wce     <= '0;
      err_cnt <= '0;
      hd_sum  <= '0;
    end else if (clear) begin
      sum_abs <= '0;
      sum_sq  <= '0;
      wce     <= '0;
      err_cnt <= '0;
      hd_sum  <= '0;
    end else if (valid) begin
      sum_abs <= sum_abs + ABS_W'(abs_err);
      sum_sq  <= sum_sq + SQ_W'(sq);
      if (abs_err > wce) begin
        wce <= abs_err;
      end
      err_cnt <= err_cnt + C_W'(abs_err != '0);
      hd_sum  <= hd_sum + H_W'(hd);
    end
  end

endmodule

// File: rtl/add8_error_eval.sv
// Exhaustive error-characterisation engine: sweeps every operand pair into
// an attached adder, realigns each result with its operands and accumulates
// the raw sums behind MAE, MSE, WCE, EP and HD.
`timescale 1ns/1ps
module add8_error_eval
  import approx_eval_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DUT_LAT = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              dut_a,
  output logic [WIDTH-1:0]              dut_b,
  input  logic [WIDTH:0]                dut_o,
  output logic [acc_abs_w(WIDTH)-1:0]   sum_abs,
  output logic [acc_sq_w(WIDTH)-1:0]    sum_sq,
  output logic [WIDTH:0]                wce,
  output logic [cnt_w(WIDTH)-1:0]       err_cnt,
  output logic [hd_w(WIDTH)-1:0]        hd_sum
);

  localparam int DCW = $clog2(DUT_LAT + 2);

  eval_state_e            state;
  logic                   start_q;
  logic [2*WIDTH-1:0]     vec;
  logic [DCW-1:0]         drain_cnt;

  logic                   al_valid;
  logic [WIDTH-1:0]       al_a;
  logic [WIDTH-1:0]       al_b;

  assign {dut_a, dut_b} = vec;

  // Sweep controller: a start seen while idle or done is captured for one
  // cycle, then the sweep begins; the vector counter wraps to 0 into DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      vec       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_q) begin
            state <= ST_RUN;
            vec   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else if (start) begin
            start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          vec <= vec + 1'b1;
          if (vec == '1) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DCW'(DUT_LAT)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (DUT_LAT == 0) begin : g_comb_dut
      assign al_valid = (state == ST_RUN);
      assign al_a     = dut_a;
      assign al_b     = dut_b;
    end else begin : g_pipe_dut
      logic [DUT_LAT-1:0] v_pipe;
      logic [2*WIDTH-1:0] ab_pipe [DUT_LAT];

      // Delay line that carries each issued vector alongside the DUT pipeline.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_pipe <= '0;
          for (int i = 0; i < DUT_LAT; i++) begin
            ab_pipe[i] <= '0;
          end
        end else begin
          v_pipe[0]  <= (state == ST_RUN);
          ab_pipe[0] <= vec;
          for (int i = 1; i < DUT_LAT; i++) begin
            v_pipe[i]  <= v_pipe[i-1];
            ab_pipe[i] <= ab_pipe[i-1];
          end
        end
      end

      assign al_valid      = v_pipe[DUT_LAT-1];
      assign {al_a, al_b}  = ab_pipe[DUT_LAT-1];
    end
  endgenerate

  add_err_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_q),
    .valid   (al_valid),
    .a       (al_a),
    .b       (al_b),
    .o       (dut_o),
    .sum_abs (sum_abs),
    .sum_sq  (sum_sq),
    .wce     (wce),
    .err_cnt (err_cnt),
    .hd_sum  (hd_sum)
  );

endmodule

// File: tb/tb_add8_error_eval.sv
// Bench for add8_error_eval: three engines (4-bit combinational, 4-bit with a
// 2-cycle registered adder, 8-bit combinational) checked against an
// exhaustive arithmetic reference of the error metrics.
`timescale 1ns/1ps
module tb_add8_error_eval;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start2, start8;
  int   mode0, mode2, mode8;
  int   assertCount;
  int   failCount;
  int unsigned randTab [65536];

  always #5 clk = ~clk;

  // Adder-under-test behaviours: 0 exact, 1 off by +1, 2 stuck at zero,
  // 3 bit0 forced low, otherwise a random lookup table.
  function automatic int unsigned modelSum(input int mode, input int unsigned a,
                                           input int unsigned b, input int w);
    int unsigned s;
    int unsigned mask;
    s    = a + b;
    mask = (32'd1 << (w + 1)) - 32'd1;
    case (mode)
      0:       return s;
      1:       return s + 32'd1;
      2:       return 32'd0;
      3:       return s & ~32'd1;
      default: return randTab[(a << w) | b] & mask;
    endcase
  endfunction

  logic [3:0]  a0, b0;
  logic [4:0]  o0;
  logic        busy0, done0;
  logic [12:0] sumAbs0;
  logic [17:0] sumSq0;
  logic [4:0]  wce0;
  logic [8:0]  errCnt0;
  logic [10:0] hdSum0;

  always_comb o0 = 5'(modelSum(mode0, 32'(a0), 32'(b0), 4));

  add8_error_eval #(.WIDTH(4), .DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .dut_a(a0), .dut_b(b0), .dut_o(o0), .sum_abs(sumAbs0), .sum_sq(sumSq0),
    .wce(wce0), .err_cnt(errCnt0), .hd_sum(hdSum0)
  );

  logic [3:0]  a2, b2;
  logic [4:0]  o2q1, o2q2;
  logic        busy2, done2;
  logic [12:0] sumAbs2;
  logic [17:0] sumSq2;
  logic [4:0]  wce2;
  logic [8:0]  errCnt2;
  logic [10:0] hdSum2;

  always @(posedge clk) begin
    o2q1 <= 5'(modelSum(mode2, 32'(a2), 32'(b2), 4));
    o2q2 <= o2q1;
  end

  add8_error_eval #(.WIDTH(4), .DUT_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .dut_a(a2), .dut_b(b2), .dut_o(o2q2), .sum_abs(sumAbs2), .sum_sq(sumSq2),
    .wce(wce2), .err_cnt(errCnt2), .hd_sum(hdSum2)
  );

  logic [7:0]  a8, b8;
  logic [8:0]  o8;
  logic        busy8, done8;
  logic [24:0] sumAbs8;
  logic [33:0] sumSq8;
  logic [8:0]  wce8;
  logic [16:0] errCnt8;
  logic [19:0] hdSum8;

  always_comb o8 = 9'(modelSum(mode8, 32'(a8), 32'(b8), 8));

  add8_error_eval #(.WIDTH(8), .DUT_LAT(0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .dut_a(a8), .dut_b(b8), .dut_o(o8), .sum_abs(sumAbs8), .sum_sq(sumSq8),
    .wce(wce8), .err_cnt(errCnt8), .hd_sum(hdSum8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic readOutputs(input int sel, output logic [63:0] sa, output logic [63:0] sq,
                             output logic [63:0] wc, output logic [63:0] ec,
                             output logic [63:0] hd, output logic [63:0] vec,
                             output logic bz, output logic dn);
    case (sel)
      0: begin
        sa = 64'(sumAbs0); sq = 64'(sumSq0); wc = 64'(wce0); ec = 64'(errCnt0);
        hd = 64'(hdSum0); vec = 64'({a0, b0}); bz = busy0; dn = done0;
      end
      2: begin
        sa = 64'(sumAbs2); sq = 64'(sumSq2); wc = 64'(wce2); ec = 64'(errCnt2);
        hd = 64'(hdSum2); vec = 64'({a2, b2}); bz = busy2; dn = done2;
      end
      default: begin
        sa = 64'(sumAbs8); sq = 64'(sumSq8); wc = 64'(wce8); ec = 64'(errCnt8);
        hd = 64'(hdSum8); vec = 64'({a8, b8}); bz = busy8; dn = done8;
      end
    endcase
  endtask

  task automatic setStart(input int sel, input logic v);
    case (sel)
      0:       start0 = v;
      2:       start2 = v;
      default: start8 = v;
    endcase
  endtask

  // Exhaustive reference: plain arithmetic over every operand pair.
  task automatic computeExpected(input int mode, input int w, output longint ea,
                                 output longint eq, output longint ew,
                                 output longint ec, output longint eh);
    longint e, ab;
    int unsigned o, s;
    ea = 0; eq = 0; ew = 0; ec = 0; eh = 0;
    for (int a = 0; a < (1 << w); a++) begin
      for (int b = 0; b < (1 << w); b++) begin
        s  = 32'(a + b);
        o  = modelSum(mode, 32'(a), 32'(b), w);
        e  = longint'(o) - longint'(s);
        ab = (e < 0) ? -e : e;
        ea += ab;
        eq += ab * ab;
        if (ab > ew) ew = ab;
        if (e != 0) ec++;
        eh += longint'($countones(o ^ s));
      end
    end
  endtask

  task automatic checkResults(input int sel, input int mode, input int w, input string name);
    longint ea, eq, ew, ec, eh;
    logic [63:0] sa, sq, wc, ecn, hd, vec;
    logic bz, dn;
    computeExpected(mode, w, ea, eq, ew, ec, eh);
    readOutputs(sel, sa, sq, wc, ecn, hd, vec, bz, dn);
    checkOutput({name, "_sum_abs"}, sa, 64'(ea));
    checkOutput({name, "_sum_sq"}, sq, 64'(eq));
    checkOutput({name, "_wce"}, wc, 64'(ew));
    checkOutput({name, "_err_cnt"}, ecn, 64'(ec));
    checkOutput({name, "_hd_sum"}, hd, 64'(eh));
  endtask

  // Pulse start on one engine, follow the sweep to done and check timing.
  task automatic applyStimulus(input int sel, input int lat, input int w, input string name);
    int n, cycles, limit;
    bit seen;
    logic [63:0] sa, sq, wc, ec, hd, vec;
    logic bz, dn;
    n      = 1 << (2 * w);
    limit  = n + lat + 50;
    cycles = 0;
    seen   = 1'b0;
    @(negedge clk);
    setStart(sel, 1'b1);
    @(posedge clk);
    #1 setStart(sel, 1'b0);
    while (!seen && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      readOutputs(sel, sa, sq, wc, ec, hd, vec, bz, dn);
      if (cycles == 1) begin
        checkOutput({name, "_busy_rise"}, 64'(bz), 64'd1);
        checkOutput({name, "_done_drop"}, 64'(dn), 64'd0);
        checkOutput({name, "_vector0"}, vec, 64'd0);
      end
      if (dn === 1'b1) seen = 1'b1;
    end
    checkOutput({name, "_done_latency"}, 64'(cycles), 64'(n + lat + 2));
    checkOutput({name, "_busy_at_done"}, 64'(bz), 64'd0);
    repeat (3) @(posedge clk);
    #1 readOutputs(sel, sa, sq, wc, ec, hd, vec, bz, dn);
    checkOutput({name, "_done_hold"}, 64'(dn), 64'd1);
  endtask

  task automatic waitVector(input int sel, input int target, input string name);
    logic [63:0] sa, sq, wc, ec, hd, vec;
    logic bz, dn;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      readOutputs(sel, sa, sq, wc, ec, hd, vec, bz, dn);
      if (vec == 64'(target)) hit = 1'b1;
    end
    checkOutput({name, "_reached"}, 64'(hit), 64'd1);
  endtask

  initial begin
    logic [63:0] sa, sq, wc, ec, hd, vec;
    logic bz, dn;
    assertCount = 0;
    failCount   = 0;
    mode0 = 0; mode2 = 0; mode8 = 0;
    start0 = 1'b0; start2 = 1'b0; start8 = 1'b0;
    for (int i = 0; i < 65536; i++) randTab[i] = $urandom;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 9; s += 2) begin
      if (s == 4 || s == 6) continue;
      readOutputs(s, sa, sq, wc, ec, hd, vec, bz, dn);
      checkOutput($sformatf("reset%0d_busy", s), 64'(bz), 64'd0);
      checkOutput($sformatf("reset%0d_done", s), 64'(dn), 64'd0);
      checkOutput($sformatf("reset%0d_vec", s), vec, 64'd0);
      checkOutput($sformatf("reset%0d_acc", s), sa | sq | wc | ec | hd, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 4-bit sweeps, combinational adder");
    mode0 = 0; applyStimulus(0, 0, 4, "exact");  checkResults(0, 0, 4, "exact");
    mode0 = 1; applyStimulus(0, 0, 4, "plus1");  checkResults(0, 1, 4, "plus1");
    mode0 = 2; applyStimulus(0, 0, 4, "zero");   checkResults(0, 2, 4, "zero");
    mode0 = 0; applyStimulus(0, 0, 4, "b2b");    checkResults(0, 0, 4, "b2b");
    mode0 = 4; applyStimulus(0, 0, 4, "rand0");  checkResults(0, 4, 4, "rand0");

    $display("[TB] 4-bit sweeps, 2-cycle registered adder");
    mode2 = 3; applyStimulus(2, 2, 4, "lat2_bit0"); checkResults(2, 3, 4, "lat2_bit0");
    mode2 = 4; applyStimulus(2, 2, 4, "lat2_rand"); checkResults(2, 4, 4, "lat2_rand");

    $display("[TB] start during run, then reset mid-sweep");
    mode0 = 2;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    waitVector(0, 50, "abort_v50");
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    readOutputs(0, sa, sq, wc, ec, hd, vec, bz, dn);
    checkOutput("ignored_start_busy", 64'(bz), 64'd1);
    checkOutput("ignored_start_vec", vec, 64'd51);
    waitVector(0, 100, "abort_v100");
    rst_n = 1'b0;
    #1 readOutputs(0, sa, sq, wc, ec, hd, vec, bz, dn);
    checkOutput("abort_busy", 64'(bz), 64'd0);
    checkOutput("abort_done", 64'(dn), 64'd0);
    checkOutput("abort_vec", vec, 64'd0);
    checkOutput("abort_sum_abs", sa, 64'd0);
    checkOutput("abort_err_cnt", ec, 64'd0);
    checkOutput("abort_hd_sum", hd, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    readOutputs(0, sa, sq, wc, ec, hd, vec, bz, dn);
    checkOutput("post_reset_idle_busy", 64'(bz), 64'd0);
    mode0 = 0; applyStimulus(0, 0, 4, "after_abort"); checkResults(0, 0, 4, "after_abort");

    $display("[TB] 8-bit sweep, stuck-at-zero adder");
    mode8 = 2;
    applyStimulus(8, 0, 8, "w8_zero");
    checkResults(8, 2, 8, "w8_zero");
    readOutputs(8, sa, sq, wc, ec, hd, vec, bz, dn);
    checkOutput("w8_zero_sum_abs_closed", sa, 64'd16711680);
    checkOutput("w8_zero_wce_closed", wc, 64'd510);
    checkOutput("w8_zero_err_cnt_closed", ec, 64'd65535);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
